lmsm_sequencer: RTL and testbench

Multi-register transfer sequencer for the pipelined core. Sits beside the IF/ID register. When a load-multiple or store-multiple instruction reaches decode, it holds PC and IF/ID and expands the instruction's 8-bit register mask into one single-register micro-op per set bit. Decode selects the micro-op stream instead of IF/ID while the sequencer is busy, and the hazard unit sees ordinary single-transfer operations.

---
 rtl/lmsm_pkg.sv | 12 +
 rtl/lmsm_sequencer_if.sv | 33 +++
 rtl/lowbit_enc.sv | 14 +
 rtl/lmsm_sequencer.sv | 64 ++++++
 tb/tb_lmsm_sequencer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/lmsm_pkg.sv
// lmsm_pkg: opcodes, state type and instruction field slices for the LM/SM sequencer
package lmsm_pkg;
  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RA_HI = 11;
  localparam int RA_LO = 9;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
  typedef enum logic {ST_IDLE, ST_SEQ} state_t;
endpackage

// File: rtl/lmsm_sequencer_if.sv
// lmsm_sequencer_if: IF/ID-side bus of the LM/SM sequencer; uop_count exists only with LMSM_PERF_EN
interface lmsm_sequencer_if;
  logic [15:0] ir_in;
  logic ir_valid;
  logic stall_in;
  logic flush;
  logic ir_sel;
  logic pc_hold;
  logic busy;
  logic uop_valid;
  logic [15:0] uop_ir;
  logic [2:0] uop_reg;
  logic [2:0] uop_offset;
  logic uop_first;
  logic uop_last;
`ifdef LMSM_PERF_EN
  logic [15:0] uop_count;
`endif
  modport master (
    output ir_in, ir_valid, stall_in, flush,
    input ir_sel, pc_hold, busy, uop_valid, uop_ir, uop_reg, uop_offset, uop_first, uop_last
`ifdef LMSM_PERF_EN
    , input uop_count
`endif
  );
  modport slave (
    input ir_in, ir_valid, stall_in, flush,
    output ir_sel, pc_hold, busy, uop_valid, uop_ir, uop_reg, uop_offset, uop_first, uop_last
`ifdef LMSM_PERF_EN
    , output uop_count
`endif
  );
endinterface

// File: rtl/lowbit_enc.sv
// lowbit_enc: index of lowest set mask bit, plus single-bit-left and empty flags
module lowbit_enc (
  input  logic [7:0] mask,
  output logic [2:0] idx,
  output logic       one_left,
  output logic       none
);
  always_comb begin
    idx = '0;
    for (int i = 7; i >= 0; i--) idx = mask[i] ? 3'(i) : idx;
  end
  assign none = mask == '0;
  assign one_left = ~none & ((mask & (mask - 8'd1)) == '0);
endmodule

// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: expands LM/SM register masks into single-register micro-ops; LMSM_PERF_EN adds uop_count
module lmsm_sequencer
  import lmsm_pkg::*;
(
  input logic clk,
  input logic rst_n,
  lmsm_sequencer_if.slave bus
);
  state_t state, state_nx;
  logic [15:0] base_ir;
  logic [7:0] mask;
  logic [2:0] cnt;
  logic [2:0] idx;
  logic one_left, none, busy, detect, issue, is_lmsm;
  logic [3:0] op;
  lowbit_enc u_enc (.mask(mask), .idx(idx), .one_left(one_left), .none(none));
  assign op = bus.ir_in[OP_HI:OP_LO];
  assign is_lmsm = (op == OP_LM) | (op == OP_SM);
  assign busy = state == ST_SEQ;
  // rst_n gates detect so every output is 0 while reset is held, whatever sits in IF/ID
  assign detect = rst_n & ~busy & bus.ir_valid & is_lmsm & (bus.ir_in[IMM_HI:IMM_LO] != '0) & ~bus.stall_in & ~bus.flush;
  assign issue = busy & ~bus.stall_in & ~bus.flush;
  always_comb begin
    state_nx = bus.flush ? ST_IDLE : detect ? ST_SEQ : (issue & one_left) ? ST_IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      base_ir <= '0;
      mask <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (bus.flush) begin
        mask <= '0;
        cnt <= '0;
      end else if (detect) begin
        base_ir <= bus.ir_in & {{(OP_HI - RA_LO + 1){1'b1}}, 9'b0};
        mask <= bus.ir_in[IMM_HI:IMM_LO];
        cnt <= '0;
      end else if (issue) begin
        mask[idx] <= 1'b0;
        cnt <= cnt + 3'd1;
      end
    end
  end
  assign bus.busy = busy;
  assign bus.uop_valid = busy & ~none;
  assign bus.uop_ir = base_ir;
  assign bus.uop_reg = idx;
  assign bus.uop_offset = cnt;
  assign bus.uop_first = bus.uop_valid & (cnt == '0);
  assign bus.uop_last = bus.uop_valid & one_left;
  assign bus.ir_sel = busy | detect;
  assign bus.pc_hold = detect | (busy & (~bus.uop_last | bus.stall_in));
`ifdef LMSM_PERF_EN
  logic [15:0] perf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf <= '0;
    else if (issue) perf <= perf + 16'(perf != 16'hFFFF);
  end
  assign bus.uop_count = perf;
`endif
endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb_lmsm_sequencer: directed vector table, corner sequences and random run against a queue-based model
module tb_lmsm_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  lmsm_sequencer_if bus ();
  lmsm_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int q[$];
  logic [15:0] m_base;
  int m_cnt;
  int m_perf;

  typedef struct {
    logic [15:0] ir;
    logic v, st, fl;
    logic sel, hold, busy, uv;
    logic [2:0] rg, off;
    logic first, last;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic m_detect();
    logic [3:0] op;
    op = bus.ir_in[15:12];
    return rst_n && q.size() == 0 && bus.ir_valid && (op == 4'h6 || op == 4'h7)
           && bus.ir_in[7:0] != 8'h00 && !bus.stall_in && !bus.flush;
  endfunction

  task automatic model_reset();
    q.delete();
    m_base = '0;
    m_cnt = 0;
    m_perf = 0;
  endtask

  task automatic model_check(input string tag);
    logic mb, det, last;
    mb = q.size() > 0;
    det = m_detect();
    last = q.size() == 1;
    chk({tag, ".ir_sel"}, 16'(bus.ir_sel), 16'(mb | det));
    chk({tag, ".pc_hold"}, 16'(bus.pc_hold), 16'(det | (mb & (!last | bus.stall_in))));
    chk({tag, ".busy"}, 16'(bus.busy), 16'(mb));
    chk({tag, ".uop_valid"}, 16'(bus.uop_valid), 16'(mb));
    chk({tag, ".uop_first"}, 16'(bus.uop_first), 16'(mb && m_cnt == 0));
    chk({tag, ".uop_last"}, 16'(bus.uop_last), 16'(last));
    if (mb) begin
      chk({tag, ".uop_reg"}, 16'(bus.uop_reg), 16'(q[0]));
      chk({tag, ".uop_offset"}, 16'(bus.uop_offset), 16'(m_cnt));
      chk({tag, ".uop_ir"}, bus.uop_ir, m_base);
    end
`ifdef LMSM_PERF_EN
    chk({tag, ".uop_count"}, bus.uop_count, 16'(m_perf));
`endif
  endtask

  task automatic model_edge();
    if (!rst_n) model_reset();
    else if (bus.flush) begin
      q.delete();
      m_cnt = 0;
    end else if (m_detect()) begin
      q.delete();
      for (int b = 0; b < 8; b++) if (bus.ir_in[b]) q.push_back(b);
      m_base = {bus.ir_in[15:9], 9'b0};
      m_cnt = 0;
    end else if (q.size() > 0 && !bus.stall_in) begin
      void'(q.pop_front());
      m_cnt++;
      if (m_perf < 16'hFFFF) m_perf++;
    end
  endtask

  task automatic apply(input logic [15:0] ir, input logic v, input logic st, input logic fl, input string tag);
    bus.ir_in = ir;
    bus.ir_valid = v;
    bus.stall_in = st;
    bus.flush = fl;
    @(negedge clk);
    model_check(tag);
  endtask

  task automatic adv();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".ir_sel"}, 16'(bus.ir_sel), 16'h0);
    chk({tag, ".pc_hold"}, 16'(bus.pc_hold), 16'h0);
    chk({tag, ".busy"}, 16'(bus.busy), 16'h0);
    chk({tag, ".uop_valid"}, 16'(bus.uop_valid), 16'h0);
    chk({tag, ".uop_first"}, 16'(bus.uop_first), 16'h0);
    chk({tag, ".uop_last"}, 16'(bus.uop_last), 16'h0);
    chk({tag, ".uop_reg"}, 16'(bus.uop_reg), 16'h0);
    chk({tag, ".uop_offset"}, 16'(bus.uop_offset), 16'h0);
    chk({tag, ".uop_ir"}, bus.uop_ir, 16'h0);
`ifdef LMSM_PERF_EN
    chk({tag, ".uop_count"}, bus.uop_count, 16'h0);
`endif
  endtask

  initial begin
    int hc;
    // LM R2 mask 0x05
    vt.push_back('{16'h6405, 1, 0, 0, 1, 1, 0, 0, 3'd0, 3'd0, 0, 0});
    vt.push_back('{16'h6405, 1, 0, 0, 1, 1, 1, 1, 3'd0, 3'd0, 1, 0});
    vt.push_back('{16'h6405, 1, 0, 0, 1, 0, 1, 1, 3'd2, 3'd1, 0, 1});
    vt.push_back('{16'h0000, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0, 0});
    // LM mask 0x0E, two-cycle stall on the second micro-op
    vt.push_back('{16'h640E, 1, 0, 0, 1, 1, 0, 0, 3'd0, 3'd0, 0, 0});
    vt.push_back('{16'h640E, 1, 0, 0, 1, 1, 1, 1, 3'd1, 3'd0, 1, 0});
    vt.push_back('{16'h640E, 1, 1, 0, 1, 1, 1, 1, 3'd2, 3'd1, 0, 0});
    vt.push_back('{16'h640E, 1, 1, 0, 1, 1, 1, 1, 3'd2, 3'd1, 0, 0});
    vt.push_back('{16'h640E, 1, 0, 0, 1, 1, 1, 1, 3'd2, 3'd1, 0, 0});
    vt.push_back('{16'h640E, 1, 0, 0, 1, 0, 1, 1, 3'd3, 3'd2, 0, 1});
    vt.push_back('{16'h0000, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0, 0});
    // flush on the first micro-op
    vt.push_back('{16'h640E, 1, 0, 0, 1, 1, 0, 0, 3'd0, 3'd0, 0, 0});
    vt.push_back('{16'h640E, 1, 0, 1, 1, 1, 1, 1, 3'd1, 3'd0, 1, 0});
    vt.push_back('{16'h0000, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0, 0});
    // zero mask passes through; stall in IDLE blocks detect
    vt.push_back('{16'h6400, 1, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0, 0});
    vt.push_back('{16'h6400, 1, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0, 0});
    vt.push_back('{16'h7003, 1, 1, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0, 0});
    vt.push_back('{16'h7003, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0, 0});

    bus.ir_in = '0;
    bus.ir_valid = 0;
    bus.stall_in = 0;
    bus.flush = 0;
    model_reset();
    #2;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    apply(16'h0000, 0, 0, 0, "post_reset");
    adv();

    for (int i = 0; i < vt.size(); i++) begin
      string t;
      t = $sformatf("tbl[%0d]", i);
      apply(vt[i].ir, vt[i].v, vt[i].st, vt[i].fl, t);
      chk({t, ".ir_sel"}, 16'(bus.ir_sel), 16'(vt[i].sel));
      chk({t, ".pc_hold"}, 16'(bus.pc_hold), 16'(vt[i].hold));
      chk({t, ".busy"}, 16'(bus.busy), 16'(vt[i].busy));
      chk({t, ".uop_valid"}, 16'(bus.uop_valid), 16'(vt[i].uv));
      chk({t, ".uop_first"}, 16'(bus.uop_first), 16'(vt[i].first));
      chk({t, ".uop_last"}, 16'(bus.uop_last), 16'(vt[i].last));
      if (vt[i].uv) begin
        chk({t, ".uop_reg"}, 16'(bus.uop_reg), 16'(vt[i].rg));
        chk({t, ".uop_offset"}, 16'(bus.uop_offset), 16'(vt[i].off));
      end
      adv();
    end

    // SM full mask: eight back-to-back micro-ops
    hc = 0;
    apply(16'h72FF, 1, 0, 0, "sm.det");
    hc += int'(bus.pc_hold);
    adv();
    for (int i = 0; i < 8; i++) begin
      apply(16'h72FF, 1, 0, 0, $sformatf("sm[%0d]", i));
      chk($sformatf("sm[%0d].reg", i), 16'(bus.uop_reg), 16'(i));
      chk($sformatf("sm[%0d].off", i), 16'(bus.uop_offset), 16'(i));
      chk($sformatf("sm[%0d].uop_ir", i), bus.uop_ir, 16'h7200);
      hc += int'(bus.pc_hold);
      adv();
    end
    apply(16'h0000, 0, 0, 0, "sm.end");
    chk("sm.hold_cycles", 16'(hc), 16'd8);
    adv();

    // async reset during the third micro-op of mask 0xFF
    apply(16'h64FF, 1, 0, 0, "rst.det");
    adv();
    apply(16'h64FF, 1, 0, 0, "rst.u0");
    adv();
    apply(16'h64FF, 1, 0, 0, "rst.u1");
    adv();
    apply(16'h64FF, 1, 0, 0, "rst.u2");
    chk("rst.u2.reg", 16'(bus.uop_reg), 16'd2);
    rst_n = 0;
    #1;
    check_zero("rst.mid");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      apply(16'h0000, 0, 0, 0, $sformatf("rst.after[%0d]", i));
      chk($sformatf("rst.after[%0d].uv", i), 16'(bus.uop_valid), 16'h0);
      adv();
    end

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [15:0] ir;
      ir = 16'($urandom);
      if ($urandom_range(0, 9) < 6) ir[15:12] = 4'h6 | 4'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 2) ir[7:0] = 8'h00;
      apply(ir, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0,
            $sformatf("rnd[%0d]", i));
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
